// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam logic [31:0] ADDR_BASE       = 32'd1024;
  localparam int unsigned WAIT_CYCLES_DEF = 4;
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait-state counter; tc flags the last cycle of a half-word access.
module sram_wait_counter
  import arm_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = en & (cnt_q == LAST);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage SRAM controller: splits 32-bit loads/stores into two 16-bit SRAM
// half-word accesses with wait states, freezing the pipeline while busy.
module mem_stage_sram_ctrl
  import arm_mem_pkg::*;
#(
  parameter int unsigned        DATA_W      = 32,
  parameter int unsigned        SRAM_DW     = 16,
  parameter int unsigned        SRAM_AW     = 18,
  parameter int unsigned        WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter logic [DATA_W-1:0]  BASE_ADDR   = arm_mem_pkg::ADDR_BASE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               memREn,
  input  logic               memWEn,
  input  logic [DATA_W-1:0]  aluRes,
  input  logic [DATA_W-1:0]  valRm,
  output logic [DATA_W-1:0]  readData,
  output logic               ready,
  output logic               freeze,
  output logic [SRAM_AW-1:0] sramAddr,
  output logic [SRAM_DW-1:0] sramDqOut,
  output logic               sramDqOe,
  input  logic [SRAM_DW-1:0] sramDqIn,
  output logic               sramWeN,
  output logic               sramOeN
);

  mem_state_t state_q, state_d;

  logic                 op_wr_q, op_wr_d;
  logic [SRAM_AW-2:0]   word_q, word_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    rd_q, rd_d;
  logic [SRAM_AW-1:0]   addr_q, addr_d;
  logic [SRAM_DW-1:0]   dq_out_q, dq_out_d;
  logic                 dq_oe_q, dq_oe_d;
  logic                 we_n_q, we_n_d;
  logic                 oe_n_q, oe_n_d;

  logic                 req_s;
  logic                 tc_s;
  logic                 busy_s;
  logic [DATA_W-1:0]    diff_s;
  logic [SRAM_AW-2:0]   word_new_s;
  logic                 unused_addr_bits_s;

  assign req_s      = memREn | memWEn;
  assign busy_s     = (state_q == LO) | (state_q == HI);
  // Out-of-window addresses simply wrap into the SRAM word space.
  assign diff_s     = aluRes - BASE_ADDR;
  assign word_new_s = diff_s[SRAM_AW:2];
  assign unused_addr_bits_s = ^{diff_s[DATA_W-1:SRAM_AW+1], diff_s[1:0]};

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clear (~busy_s | tc_s),
    .en    (busy_s),
    .tc    (tc_s)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = req_s ? LO : IDLE;
      LO:      state_d = tc_s ? HI : LO;
      HI:      state_d = tc_s ? DONE : HI;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request attributes are captured only when leaving IDLE; store wins a tie.
  always_comb begin
    op_wr_d = op_wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    if ((state_q == IDLE) && req_s) begin
      op_wr_d = memWEn;
      word_d  = word_new_s;
      wdata_d = valRm;
    end else begin
      op_wr_d = op_wr_q;
      word_d  = word_q;
      wdata_d = wdata_q;
    end
  end

  // SRAM pins are registered from the next state so they line up with LO/HI.
  always_comb begin
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    dq_oe_d  = 1'b0;
    we_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    case (state_d)
      LO: begin
        addr_d = {word_d, 1'b0};
        if (op_wr_d) begin
          dq_out_d = wdata_d[SRAM_DW-1:0];
          dq_oe_d  = 1'b1;
          we_n_d   = 1'b0;
        end else begin
          oe_n_d   = 1'b0;
        end
      end
      HI: begin
        addr_d = {word_d, 1'b1};
        if (op_wr_d) begin
          dq_out_d = wdata_d[DATA_W-1:SRAM_DW];
          dq_oe_d  = 1'b1;
          we_n_d   = 1'b0;
        end else begin
          oe_n_d   = 1'b0;
        end
      end
      default: begin
        addr_d   = addr_q;
        dq_out_d = dq_out_q;
      end
    endcase
  end

  always_comb begin
    rd_d = rd_q;
    if ((state_q == LO) && tc_s && !op_wr_q) begin
      rd_d = {rd_q[DATA_W-1:SRAM_DW], sramDqIn};
    end else if ((state_q == HI) && tc_s && !op_wr_q) begin
      rd_d = {sramDqIn, rd_q[SRAM_DW-1:0]};
    end else begin
      rd_d = rd_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_wr_q  <= 1'b0;
      word_q   <= {(SRAM_AW-1){1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      rd_q     <= {DATA_W{1'b0}};
      addr_q   <= {SRAM_AW{1'b0}};
      dq_out_q <= {SRAM_DW{1'b0}};
      dq_oe_q  <= 1'b0;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_wr_q  <= op_wr_d;
      word_q   <= word_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
      dq_oe_q  <= dq_oe_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
    end
  end

  assign ready     = (state_q == DONE) | ((state_q == IDLE) & ~memREn & ~memWEn);
  assign freeze    = ~ready;
  assign readData  = rd_q;
  assign sramAddr  = addr_q;
  assign sramDqOut = dq_out_q;
  assign sramDqOe  = dq_oe_q;
  assign sramWeN   = we_n_q;
  assign sramOeN   = oe_n_q;

endmodule
